// File: rtl/pipelined_rca_adder.sv
// rtl/pipelined_rca_adder.sv - Pipelined ripple-carry adder/subtractor with valid/ready handshake
//
// Purpose: WIDTH-bit add/subtract split into STAGES equal slices. Each stage adds one
//          slice and registers the carry. Upper operand slices and finished result
//          slices ride alongside in skew and deskew registers.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation on a/b/c_in/sub is valid
//   in_ready   block accepts an operation this cycle (combinational, !stall)
//   a, b       operands, WIDTH bits
//   c_in       carry in, ignored when sub=1
//   sub        1: s = a - b, 0: s = a + b + c_in
//   out_valid  s/c_out/ovf valid
//   out_ready  consumer accepts the result this cycle
//   s          result modulo 2^WIDTH
//   c_out      carry out of the MSB (1 = no borrow on subtract)
//   ovf        signed overflow
module pipelined_rca_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_param
    $error("pipelined_rca_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // The whole pipe freezes while the head result is waiting; bubbles are not squeezed out.
  logic w_stall;
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet consumed when entering stage k; the low SW of them are added here.
    localparam int IW = WIDTH - k * SW;

    logic [IW-1:0]         w_a;
    logic [IW-1:0]         w_b;
    logic                  w_c;
    logic                  w_v;
    logic [SW:0]           w_sum;
    logic [(k+1)*SW-1:0]   w_s_nxt;

    logic                  r_v;
    logic                  r_c;
    logic [(k+1)*SW-1:0]   r_s;

    if (k == 0) begin : g_in
      // Subtraction folds into the first slice: a + ~b + 1.
      assign w_a     = a;
      assign w_b     = sub ? ~b : b;
      assign w_c     = sub | c_in;
      assign w_v     = in_valid && !w_stall;
      assign w_s_nxt = w_sum[SW-1:0];
    end else begin : g_in
      assign w_a     = g_stage[k-1].g_skew.r_a;
      assign w_b     = g_stage[k-1].g_skew.r_b;
      assign w_c     = g_stage[k-1].r_c;
      assign w_v     = g_stage[k-1].r_v;
      assign w_s_nxt = {w_sum[SW-1:0], g_stage[k-1].r_s};
    end

    assign w_sum = {1'b0, w_a[SW-1:0]} + {1'b0, w_b[SW-1:0]} + {{SW{1'b0}}, w_c};

    // Data only moves with a valid op so s/c_out/ovf stay put across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (!w_stall) begin
        r_v <= w_v;
        if (w_v) begin
          r_c <= w_sum[SW];
          r_s <= w_s_nxt;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [IW-SW-1:0] r_a;
      logic [IW-SW-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (!w_stall && w_v) begin
          r_a <= w_a[IW-1:SW];
          r_b <= w_b[IW-1:SW];
        end
      end
    end else begin : g_last
      logic r_ovf;

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (!w_stall && w_v) begin
          r_ovf <= (w_a[SW-1] ^ w_b[SW-1] ^ w_sum[SW-1]) ^ w_sum[SW];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign s         = g_stage[STAGES-1].r_s;
  assign c_out     = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule
